// File: rtl/spi_master_interface.sv
// SPI master for the SPI RAM slave: one host command per 10-bit frame,
// with an 8-bit MISO reply captured for read-data commands.
module spi_master_interface #(
   parameter int LEAD_CYCLES     = 2,
   parameter int HOLD_CYCLES     = 2,
   parameter int TURNAROUND      = 2,
   parameter int DESELECT_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_type,
   input  logic [7:0] cmd_data,
   output logic       rd_valid,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       MOSI,
   input  logic       MISO,
   output logic       SS_n
);

   typedef enum logic [2:0] {
      IDLE, LEAD, SHIFT, HOLD, TURN, RECV, DESEL
   } state_t;

   localparam logic [3:0] LEAD_LD  = 4'(LEAD_CYCLES - 1);
   localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYCLES - 1);
   localparam logic [3:0] TURN_LD  = 4'(TURNAROUND - 1);
   localparam logic [3:0] DESEL_LD = 4'(DESELECT_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [9:0] sh_q, sh_d;
   logic [7:0] rx_q, rx_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       rd_valid_q, rd_valid_d;
   logic       mosi_q, mosi_d;
   logic       ss_n_q, ss_n_d;
   logic       is_rd_q, is_rd_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      rx_d       = rx_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      mosi_d     = 1'b0;
      ss_n_d     = ss_n_q;
      is_rd_d    = is_rd_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               sh_d    = {cmd_type, cmd_data};
               is_rd_d = (cmd_type == 2'b11);
               ss_n_d  = 1'b0;
               cnt_d   = LEAD_LD;
               state_d = LEAD;
            end
         end
         LEAD: begin
            if (cnt_q == 4'd0) begin
               mosi_d  = sh_q[9];
               sh_d    = {sh_q[8:0], 1'b0};
               cnt_d   = 4'd9;
               state_d = SHIFT;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         SHIFT: begin
            if (cnt_q == 4'd0) begin
               if (!is_rd_q) begin
                  cnt_d   = HOLD_LD;
                  state_d = HOLD;
               end else if (TURNAROUND == 0) begin
                  cnt_d   = 4'd7;
                  state_d = RECV;
               end else begin
                  cnt_d   = TURN_LD;
                  state_d = TURN;
               end
            end else begin
               mosi_d = sh_q[9];
               sh_d   = {sh_q[8:0], 1'b0};
               cnt_d  = cnt_q - 4'd1;
            end
         end
         HOLD: begin
            if (cnt_q == 4'd0) begin
               ss_n_d  = 1'b1;
               cnt_d   = DESEL_LD;
               state_d = DESEL;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         TURN: begin
            if (cnt_q == 4'd0) begin
               cnt_d   = 4'd7;
               state_d = RECV;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RECV: begin
            // rd_data only moves once the whole byte is in
            rx_d = {rx_q[6:0], MISO};
            if (cnt_q == 4'd0) begin
               rd_data_d  = rx_d;
               rd_valid_d = 1'b1;
               ss_n_d     = 1'b1;
               cnt_d      = DESEL_LD;
               state_d    = DESEL;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DESEL: begin
            if (cnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         sh_q       <= 10'd0;
         rx_q       <= 8'd0;
         rd_data_q  <= 8'd0;
         rd_valid_q <= 1'b0;
         mosi_q     <= 1'b0;
         ss_n_q     <= 1'b1;
         is_rd_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         rx_q       <= rx_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         mosi_q     <= mosi_d;
         ss_n_q     <= ss_n_d;
         is_rd_q    <= is_rd_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = ~cmd_ready;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign MOSI      = mosi_q;
   assign SS_n      = ss_n_q;

endmodule

// File: tb/tb_spi_master_interface.sv
// Bench for spi_master_interface: host driver, slave+RAM model on the
// serial side, scoreboard queues for frames and read replies.
module tb_spi_master_interface;

   localparam int L = 2;
   localparam int H = 2;
   localparam int T = 2;
   localparam int D = 1;

   typedef struct {
      logic [9:0] fr;
      int         len;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready, busy;
   logic [1:0] cmd_type;
   logic [7:0] cmd_data;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       MOSI, MISO, SS_n;

   logic       cmd_valid2, cmd_ready2, busy2;
   logic [1:0] cmd_type2;
   logic [7:0] cmd_data2;
   logic       rd_valid2;
   logic [7:0] rd_data2;
   logic       mosi2, miso2, ss2;

   int n_chk = 0;
   int n_err = 0;

   exp_t       exp_q[$];
   logic [7:0] rd_q[$];
   logic [7:0] ref_ram [256];
   logic [7:0] sl_ram [256];
   logic [7:0] ref_addr = 0, ref_raddr = 0;
   logic [7:0] sl_addr = 0, sl_raddr = 0, sl_reply = 0;
   logic [9:0] sl_fr = 0;
   int         sl_lo = 0, sl_hi = 0, cur_len = 0;
   logic       sl_prev = 1'b1;
   bit         gap_chk = 0, gap_armed = 0, abort_pending = 0;
   int         rd_cnt = 0, rd_pushed = 0;
   logic [7:0] last_rd = 0;
   logic       mon_ss_prev = 1'b1, mon_rdv_prev = 1'b0;

   logic [7:0] pat2 = 8'h96;
   int         lo2 = 0, rdv2_cnt = 0;
   logic       ss2_prev = 1'b1;

   always #5 clk = ~clk;

   spi_master_interface #(
      .LEAD_CYCLES(L), .HOLD_CYCLES(H),
      .TURNAROUND(T), .DESELECT_CYCLES(D)
   ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_type(cmd_type), .cmd_data(cmd_data),
      .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
      .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n)
   );

   spi_master_interface #(
      .LEAD_CYCLES(1), .HOLD_CYCLES(2),
      .TURNAROUND(0), .DESELECT_CYCLES(1)
   ) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
      .cmd_type(cmd_type2), .cmd_data(cmd_data2),
      .rd_valid(rd_valid2), .rd_data(rd_data2), .busy(busy2),
      .MOSI(mosi2), .MISO(miso2), .SS_n(ss2)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic send(input logic [1:0] t, input logic [7:0] d,
                       input bit hold);
      int   n = 0;
      exp_t e;
      cmd_type  = t;
      cmd_data  = d;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         chk("send_timeout", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      e.fr  = {t, d};
      e.len = (t == 2'b11) ? L + 10 + T + 8 : L + 10 + H;
      exp_q.push_back(e);
      unique case (t)
         2'b00: ref_addr = d;
         2'b01: ref_ram[ref_addr] = d;
         2'b10: ref_raddr = d;
         default: begin
            rd_q.push_back(ref_ram[ref_raddr]);
            rd_pushed++;
         end
      endcase
      @(posedge clk);
      #1;
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("idle_timeout", 0, 1);
   endtask

   // slave + RAM model on the main DUT's serial pins
   always @(negedge clk) begin
      if (!SS_n) begin
         if (sl_prev) begin
            if (gap_armed && gap_chk) chk("ss_gap", sl_hi, D + 1);
            gap_armed = gap_chk;
            sl_lo = 0;
            sl_fr = 0;
         end
         chk("ready_low", {busy, cmd_ready}, 2'b10);
         if (sl_lo < L) begin
            chk("lead_mosi", MOSI, 0);
         end else if (sl_lo < L + 10) begin
            sl_fr = {sl_fr[8:0], MOSI};
         end else begin
            chk("tail_mosi", MOSI, 0);
         end
         if (sl_lo == L + 9) begin
            if (exp_q.size() == 0) begin
               chk("frame_extra", 1, 0);
            end else begin
               chk("frame", sl_fr, exp_q[0].fr);
               cur_len = exp_q[0].len;
               exp_q.delete(0);
            end
            unique case (sl_fr[9:8])
               2'b00: sl_addr = sl_fr[7:0];
               2'b01: sl_ram[sl_addr] = sl_fr[7:0];
               2'b10: sl_raddr = sl_fr[7:0];
               default: sl_reply = sl_ram[sl_raddr];
            endcase
         end
         if (sl_lo >= L + 10 + T && sl_lo < L + 18 + T)
            MISO = sl_reply[7 - (sl_lo - (L + 10 + T))];
         else
            MISO = 1'b0;
         sl_lo++;
      end else begin
         MISO = 1'b0;
         if (!sl_prev) begin
            if (sl_lo < L + 10) begin
               chk("abort_expected", abort_pending, 1);
               if (exp_q.size() > 0) exp_q.delete(0);
               abort_pending = 0;
            end else begin
               chk("ss_len", sl_lo, cur_len);
            end
            sl_hi = 0;
         end
         sl_hi++;
      end
      sl_prev = SS_n;
   end

   // read-reply scoreboard
   always @(negedge clk) begin
      if (!rst_n) last_rd = 8'h00;
      if (rd_valid) begin
         rd_cnt++;
         chk("rd_pulse", mon_rdv_prev, 0);
         chk("rd_ss_rise", {mon_ss_prev, SS_n}, 2'b01);
         if (rd_q.size() == 0) begin
            chk("rd_extra", 1, 0);
         end else begin
            chk("rd_data", rd_data, rd_q[0]);
            last_rd = rd_q[0];
            rd_q.delete(0);
         end
      end else begin
         chk("rd_hold", rd_data, last_rd);
      end
      mon_ss_prev  = SS_n;
      mon_rdv_prev = rd_valid;
   end

   // short-lead, zero-turnaround instance with a fixed reply
   always @(negedge clk) begin
      if (!ss2) begin
         if (lo2 >= 11 && lo2 < 19) miso2 = pat2[7 - (lo2 - 11)];
         else miso2 = 1'b0;
         lo2++;
      end else begin
         miso2 = 1'b0;
         if (!ss2_prev) chk("d2_ss_len", lo2, 19);
         lo2 = 0;
      end
      if (rd_valid2) begin
         rdv2_cnt++;
         chk("d2_rd_data", rd_data2, 8'h96);
         chk("d2_rd_ss_rise", {ss2_prev, ss2}, 2'b01);
      end
      ss2_prev = ss2;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) begin
         ref_ram[i] = 8'h00;
         sl_ram[i]  = 8'h00;
      end
      rst_n      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_type   = 2'b00;
      cmd_data   = 8'h00;
      MISO       = 1'b0;
      cmd_valid2 = 1'b0;
      cmd_type2  = 2'b00;
      cmd_data2  = 8'h00;
      miso2      = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ss_n", SS_n, 1);
      chk("rst_mosi", MOSI, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 8'h00);
      chk("rst_ready", {cmd_ready, busy}, 2'b10);
      rst_n = 1'b1;
      @(negedge clk);

      send(2'b00, 8'h5A, 0);
      wait_idle();
      chk("idle_busy", busy, 0);

      gap_chk = 1;
      send(2'b00, 8'h10, 1);
      send(2'b01, 8'hC3, 1);
      send(2'b10, 8'h10, 1);
      send(2'b11, 8'h00, 0);
      wait_idle();
      gap_chk = 0;

      send(2'b00, 8'h20, 0);
      send(2'b01, 8'h96, 0);
      send(2'b10, 8'h20, 0);
      send(2'b11, 8'hFF, 0);
      wait_idle();

      abort_pending = 1;
      send(2'b11, 8'h00, 0);
      repeat (L + 5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ss_n", SS_n, 1);
      chk("abort_mosi", MOSI, 0);
      chk("abort_ready", cmd_ready, 1);
      chk("abort_rd_valid", rd_valid, 0);
      rd_q.delete(rd_q.size() - 1);
      rd_pushed--;
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      send(2'b11, 8'h00, 0);
      wait_idle();

      send(2'b01, 8'hA5, 0);
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (cmd_ready) begin
            cmd_valid = 1'b0;
            break;
         end
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_type  = 2'($urandom_range(0, 3));
         cmd_data  = 8'($urandom_range(0, 255));
      end
      cmd_valid = 1'b0;
      send(2'b11, 8'h3C, 0);
      wait_idle();

      @(negedge clk);
      cmd_type2  = 2'b11;
      cmd_data2  = 8'h00;
      cmd_valid2 = 1'b1;
      @(posedge clk);
      #1 cmd_valid2 = 1'b0;
      n = 0;
      @(negedge clk);
      while (!cmd_ready2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("d2_timeout", 0, 1);

      repeat (5) @(negedge clk);
      chk("frames_left", exp_q.size(), 0);
      chk("rd_left", rd_q.size(), 0);
      chk("rd_count", rd_cnt, rd_pushed);
      chk("d2_rd_count", rdv2_cnt, 1);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/spi_master_interface.md
Name: spi_master_interface

Overview:
- SPI master that drives the team's SPI RAM slave over the same serial frame format.
- Accepts one command at a time from a host-side valid/ready port.
- Serializes each command as a 10-bit frame {cmd[1:0], data[7:0]}, MSB first, onto MOSI, framed by SS_n.
- For read-data commands (cmd 2'b11) it captures the 8-bit reply from MISO and returns it to the host.
- Serial clock is the shared system clock; no SCLK output.

Parameters:
- LEAD_CYCLES, 2, cycles SS_n is low with MOSI=0 before frame bit 9 (covers slave select-detect plus dummy bit); range 1..15.
- HOLD_CYCLES, 2, cycles SS_n stays low after bit 0 on non-read commands (slave memory commit); range 1..15.
- TURNAROUND, 2, cycles after bit 0 on cmd 2'b11 before the first MISO sample; range 0..15.
- DESELECT_CYCLES, 1, cycles SS_n is held high after each frame before returning to IDLE; range 1..15.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host command request.
- cmd_ready  out  1  high exactly when FSM is IDLE.
- cmd_type  in  2  00 write addr, 01 write data, 10 read addr, 11 read data.
- cmd_data  in  8  payload; don't-care content for cmd 11 but still shifted.
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- rd_data  out  8  byte received on MISO, MSB first.
- busy  out  1  equals ~cmd_ready.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.
- SS_n  out  1  active-low slave select.

Behaviour:
Reset:
- rst_n low asynchronously forces: state IDLE, SS_n=1, MOSI=0, rd_valid=0, rd_data=8'h00, all counters 0.
- cmd_ready=1 and busy=0 during and after reset.
- Reset mid-frame aborts the frame immediately with no rd_valid.

Acceptance:
- A command is accepted on a posedge with cmd_valid && cmd_ready.
- At that edge, {cmd_type, cmd_data} is latched into a 10-bit shift register, SS_n goes low and the state moves to LEAD.
- cmd_valid while busy is ignored and has no effect.

States (MOSI, SS_n, SCLK-edge outputs registered):
- IDLE: SS_n=1, MOSI=0. Accept → LEAD.
- LEAD: LEAD_CYCLES cycles, SS_n=0, MOSI=0. → SHIFT.
- SHIFT: exactly 10 cycles; cycle k drives frame bit 9-k on MOSI. After bit 0: cmd 11 → TURN (or RECV if TURNAROUND=0); otherwise → HOLD.
- HOLD: HOLD_CYCLES cycles, SS_n=0, MOSI=0. → DESEL.
- TURN: TURNAROUND cycles, SS_n=0, MOSI=0. → RECV.
- RECV: 8 cycles, SS_n=0, MOSI=0. MISO is sampled each posedge into rd_data shift, MSB first. On the 8th sampling edge → DESEL, with rd_data updated and rd_valid=1 for the following cycle only.
- DESEL: DESELECT_CYCLES cycles, SS_n=1, MOSI=0. → IDLE.

Timing:
- SS_n low duration: LEAD_CYCLES+10+HOLD_CYCLES for cmd 00/01/10; LEAD_CYCLES+10+TURNAROUND+8 for cmd 11.
- Minimum SS_n high between frames: DESELECT_CYCLES+1 (one IDLE cycle is mandatory).
- cmd_valid held high gives back-to-back frames at that minimum gap.
- rd_data holds its value until the next completed read; it is unchanged by non-read frames.
- rd_valid never asserts for cmd 00/01/10.

Counters:
- One 4-bit down counter reused across states, reloaded on every state entry.
- Zero-length TURNAROUND skips TURN entirely.

Test Plan:
- Reset, then cmd 00 data 8'h5A → SS_n low 14 cycles; MOSI: 0,0, then 0,0,0,1,0,1,1,0,1,0; SS_n high 1 cycle then IDLE; cmd_ready low throughout; no rd_valid.
- Back-to-back sequence (00 8'h10, 01 8'hC3, 10 8'h10, 11 8'h00), cmd_valid held, behavioural slave+RAM model → rd_data=8'hC3, exactly one rd_valid pulse, SS_n high exactly 2 cycles between frames.
- cmd 11 with MISO model driving 8'b1001_0110 starting TURNAROUND cycles after bit 0 → rd_data=8'h96, rd_valid one cycle after the 8th sample, SS_n rises on the same edge.
- rst_n pulsed low during SHIFT bit 4 (async, mid-cycle) → SS_n=1 and MOSI=0 immediately, cmd_ready=1, no rd_valid; next command completes normally.
- cmd_valid toggled with new cmd_type/cmd_data while busy → ignored; the frame in flight is bit-exact to the originally latched command.
- TURNAROUND=0, LEAD_CYCLES=1 build → first MISO sample on the edge right after bit 0; read frame SS_n low for 19 cycles.
